// File: rtl/time_display.sv
// Four-digit multiplexed seven-segment driver showing the selected song time as MM.SS,
// blanking the whole display on alternate half-periods while paused.
module time_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 50000000
) (
   input  logic       clk,
   input  logic       RESET_N,
   input  logic       ss,
   input  logic       ispaused,
   input  logic [5:0] mins1,
   input  logic [5:0] secs1,
   input  logic [5:0] mins2,
   input  logic [5:0] secs2,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [RW-1:0] rcnt_reg, rcnt_next;
   logic [1:0]    didx_reg, didx_next;
   logic [BW-1:0] bcnt_reg, bcnt_next;
   logic          bphase_reg, bphase_next;
   logic [5:0]    snap_m_reg, snap_m_next;
   logic [5:0]    snap_s_reg, snap_s_next;
   logic [6:0]    seg_next;
   logic [3:0]    an_next;
   logic          dp_next;
   logic          rcnt_wrap;
   logic [7:0]    bcd_m, bcd_s;
   logic [15:0]   bcd_all;
   logic [3:0]    digit [4];

   function automatic logic [5:0] clamp59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

   // Compare/subtract chain; input is already clamped to 0..59.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [5:0] r;
      logic [3:0] t;
      r = v;
      t = 4'd0;
      if (r >= 6'd50) begin
         r = r - 6'd50;  t = 4'd5;
      end else if (r >= 6'd40) begin
         r = r - 6'd40;  t = 4'd4;
      end else if (r >= 6'd30) begin
         r = r - 6'd30;  t = 4'd3;
      end else if (r >= 6'd20) begin
         r = r - 6'd20;  t = 4'd2;
      end else if (r >= 6'd10) begin
         r = r - 6'd10;  t = 4'd1;
      end
      return {t, r[3:0]};
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      rcnt_wrap = (rcnt_reg == RW'(REFRESH_DIV - 1));
      rcnt_next = rcnt_wrap ? '0 : rcnt_reg + RW'(1);
      didx_next = rcnt_wrap ? didx_reg + 2'd1 : didx_reg;
      snap_m_next = snap_m_reg;
      snap_s_next = snap_s_reg;
      // Sample once per scan so all four digits come from one coherent time value.
      if (rcnt_wrap && (didx_reg == 2'd3)) begin
         snap_m_next = clamp59(ss ? mins2 : mins1);
         snap_s_next = clamp59(ss ? secs2 : secs1);
      end
   end

   always_comb begin
      bcnt_next   = '0;
      bphase_next = 1'b0;
      if (ispaused) begin
         if (bcnt_reg == BW'(BLINK_DIV - 1)) begin
            bcnt_next   = '0;
            bphase_next = ~bphase_reg;
         end else begin
            bcnt_next   = bcnt_reg + BW'(1);
            bphase_next = bphase_reg;
         end
      end
   end

   assign bcd_m   = to_bcd(snap_m_reg);
   assign bcd_s   = to_bcd(snap_s_reg);
   assign bcd_all = {bcd_m, bcd_s};

   // digit[0] = seconds ones ... digit[3] = minutes tens, matching didx order.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         assign digit[gi] = bcd_all[gi*4 +: 4];
      end
   endgenerate

   always_comb begin
      an_next  = 4'b1111;
      seg_next = 7'b1111111;
      dp_next  = 1'b1;
      if (!bphase_reg) begin
         an_next  = ~(4'b0001 << didx_reg);
         seg_next = seg_of(digit[didx_reg]);
         dp_next  = (didx_reg != 2'd2);
      end
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         rcnt_reg   <= '0;
         didx_reg   <= 2'd0;
         bcnt_reg   <= '0;
         bphase_reg <= 1'b0;
         snap_m_reg <= 6'd0;
         snap_s_reg <= 6'd0;
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
      end else begin
         rcnt_reg   <= rcnt_next;
         didx_reg   <= didx_next;
         bcnt_reg   <= bcnt_next;
         bphase_reg <= bphase_next;
         snap_m_reg <= snap_m_next;
         snap_s_reg <= snap_s_next;
         an         <= an_next;
         seg        <= seg_next;
         dp         <= dp_next;
      end
   end

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display with REFRESH_DIV=4, BLINK_DIV=8.
module tb_time_display;

   logic       clk;
   logic       RESET_N;
   logic       ss;
   logic       ispaused;
   logic [5:0] mins1, secs1, mins2, secs2;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   int checks = 0;
   int fails  = 0;
   int cyc;

   typedef struct {
      string      name;
      logic       ss;
      logic [5:0] m1, s1, m2, s2;
      int         exp_m, exp_s;
   } vec_t;

   vec_t       vecs [7];
   logic [6:0] seg_code [10];
   localparam logic [11:0] BLANK = {4'b1111, 7'b1111111, 1'b1};

   time_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
      .clk(clk), .RESET_N(RESET_N), .ss(ss), .ispaused(ispaused),
      .mins1(mins1), .secs1(secs1), .mins2(mins2), .secs2(secs2),
      .seg(seg), .an(an), .dp(dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release: output after edge n shows digit ((n-1)/4)%4.
   always @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic cmp_blank(input string name);
      logic [11:0] act;
      act = {an, seg, dp};
      checks++;
      if (act !== BLANK) begin
         fails++;
         $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1",
                  name, an, seg, dp);
      end
   endtask

   task automatic check_cycle(input int em, input int es, input bit blank, input string name);
      int d, dig;
      logic [3:0]  an_e, one;
      logic [11:0] exp_v, act;
      @(negedge clk);
      d = ((cyc - 1) / 4) % 4;
      case (d)
         0:       dig = es % 10;
         1:       dig = es / 10;
         2:       dig = em % 10;
         default: dig = em / 10;
      endcase
      one  = 4'b0001;
      an_e = ~(one << d);
      exp_v = blank ? BLANK : {an_e, seg_code[dig], (d == 2) ? 1'b0 : 1'b1};
      act = {an, seg, dp};
      checks++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                  name, cyc, an, seg, dp, exp_v[11:8], exp_v[7:1], exp_v[0]);
      end
   endtask

   task automatic check_scan(input int em, input int es, input int n, input string name);
      for (int k = 0; k < n; k++) check_cycle(em, es, 1'b0, name);
   endtask

   // Wait until the snapshot edge has consumed the current inputs.
   task automatic align_scan();
      @(negedge clk);
      while (cyc % 16 != 0) @(negedge clk);
   endtask

   initial begin
      seg_code[0] = 7'b1000000; seg_code[1] = 7'b1111001;
      seg_code[2] = 7'b0100100; seg_code[3] = 7'b0110000;
      seg_code[4] = 7'b0011001; seg_code[5] = 7'b0010010;
      seg_code[6] = 7'b0000010; seg_code[7] = 7'b1111000;
      seg_code[8] = 7'b0000000; seg_code[9] = 7'b0010000;

      vecs[0] = '{"digit_map_12_34", 1'b0, 6'd12, 6'd34, 6'd0,  6'd0,  12, 34};
      vecs[1] = '{"clamp_60_63",     1'b0, 6'd60, 6'd63, 6'd0,  6'd0,  59, 59};
      vecs[2] = '{"ss1_05_09",       1'b1, 6'd1,  6'd1,  6'd5,  6'd9,   5,  9};
      vecs[3] = '{"ss1_clamp_min",   1'b1, 6'd3,  6'd3,  6'd63, 6'd40, 59, 40};
      vecs[4] = '{"ss0_07_00",       1'b0, 6'd7,  6'd0,  6'd50, 6'd1,   7,  0};
      vecs[5] = '{"ss1_48_26",       1'b1, 6'd9,  6'd9,  6'd48, 6'd26, 48, 26};
      vecs[6] = '{"ss0_36_17",       1'b0, 6'd36, 6'd17, 6'd2,  6'd2,  36, 17};

      RESET_N = 1'b0; ss = 1'b0; ispaused = 1'b0;
      mins1 = 6'd0; secs1 = 6'd0; mins2 = 6'd0; secs2 = 6'd0;

      // Reset held with clock running, then release.
      repeat (3) begin
         @(negedge clk);
         cmp_blank("reset_hold");
      end
      RESET_N = 1'b1;
      check_scan(0, 0, 16, "post_reset_00_00");
      $display("reset: post-release scan checked");

      foreach (vecs[i]) begin
         ss = vecs[i].ss;
         mins1 = vecs[i].m1; secs1 = vecs[i].s1;
         mins2 = vecs[i].m2; secs2 = vecs[i].s2;
         align_scan();
         check_scan(vecs[i].exp_m, vecs[i].exp_s, 16, vecs[i].name);
         $display("vector %s: expected %0d.%0d", vecs[i].name, vecs[i].exp_m, vecs[i].exp_s);
      end

      // Blink: inputs stay at the last vector (36.17).
      ispaused = 1'b1;
      for (int k = 1; k <= 44; k++)
         check_cycle(36, 17, (((k - 1) / 8) % 2) == 1, "blink");
      ispaused = 1'b0;
      check_cycle(36, 17, 1'b1, "unpause_still_blank");
      for (int k = 0; k < 10; k++) check_cycle(36, 17, 1'b0, "unpause_visible");
      $display("blink: 44 paused cycles and resume checked");

      // Mid-scan select change while didx=1.
      ss = 1'b0; mins1 = 6'd12; secs1 = 6'd34;
      align_scan();
      check_scan(12, 34, 20, "midscan_before");
      ss = 1'b1; mins2 = 6'd5; secs2 = 6'd9;
      check_scan(12, 34, 12, "midscan_rest_of_scan");
      check_scan(5, 9, 16, "midscan_next_scan");
      $display("midscan: select change checked");

      // Async reset while minutes-ones digit is shown.
      begin
         int guard = 0;
         @(negedge clk);
         while ((((cyc - 1) / 4) % 4) != 2 && guard < 32) begin
            @(negedge clk);
            guard++;
         end
         checks++;
         if (an !== 4'b1011) begin
            fails++;
            $display("FAIL async_reset_setup: got an=%b, expected an=1011", an);
         end
      end
      #2 RESET_N = 1'b0;
      #1 cmp_blank("async_reset_immediate");
      @(negedge clk);
      cmp_blank("async_reset_held");
      RESET_N = 1'b1;
      check_scan(0, 0, 16, "after_async_reset");
      $display("async reset: blank and restart checked");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
